// File: rtl/interp_phase_ctrl.sv
// Symbol-timing controller: waits for the polyphase delay line to fill, then issues symbol strobes with branch/mu and slip/stuff pulses.
// Outputs are registered one cycle after the qualifying valid sample; there is no backpressure, so strobes are never stalled.
module interp_phase_ctrl #(
  parameter int OSF      = 20,
  parameter int TAPS_PPH = 5,
  parameter int FRAC_W   = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              iq_raw_val_i,
  input  logic [31:0]       adj_i,
  input  logic              adj_val_i,
  output logic              sym_valid_o,
  output logic [4:0]        phase_int_o,
  output logic [FRAC_W-1:0] mu_o,
  output logic              slip_o,
  output logic              stuff_o,
  output logic              run_o
);

  localparam int DEPTH  = OSF * TAPS_PPH;
  localparam int TAU_W  = 5 + FRAC_W;
  localparam int SUM_W  = TAU_W + 2;
  localparam int CTR_W  = $clog2(OSF);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic signed [31:0]      LIM  = 32'(longint'(OSF / 2) << FRAC_W);
  localparam logic signed [SUM_W-1:0] WRAP = SUM_W'(longint'(OSF) << FRAC_W);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [CTR_W-1:0]    ctr;
  logic [TAU_W-1:0]    tau;
  logic                skip_pend, stuff_pend;

  logic                run_act, ctr_last, strobe_norm, stuff_evt;
  logic                wrap_hi, wrap_lo, skip_nxt, stuff_nxt;
  logic signed [31:0]  adj_c;
  logic signed [SUM_W-1:0] tau_sum;
  logic [TAU_W-1:0]    tau_wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = FILL;
        FILL:    if (iq_raw_val_i && fill_cnt == FILL_W'(DEPTH - 1)) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign run_o       = (state == RUN);
  assign run_act     = (state == RUN) && en_i;
  assign ctr_last    = (ctr == CTR_W'(OSF - 1));
  assign strobe_norm = run_act && iq_raw_val_i && ctr_last;
  assign stuff_evt   = run_act && iq_raw_val_i && !ctr_last && stuff_pend;

  // Pending flags: consume first, then a wrap in the opposite direction cancels silently.
  always_comb begin
    adj_c = $signed(adj_i);
    if ($signed(adj_i) > LIM)       adj_c = LIM;
    else if ($signed(adj_i) < -LIM) adj_c = -LIM;

    tau_sum = $signed({2'b00, tau}) + $signed({{(SUM_W-32){adj_c[31]}}, adj_c});
    wrap_hi = (tau_sum >= WRAP);
    wrap_lo = tau_sum[SUM_W-1];

    tau_wrap = tau_sum[TAU_W-1:0];
    if (wrap_hi)      tau_wrap = TAU_W'(tau_sum - WRAP);
    else if (wrap_lo) tau_wrap = TAU_W'(tau_sum + WRAP);

    skip_nxt  = skip_pend && !strobe_norm;
    stuff_nxt = stuff_pend && !stuff_evt;
    if (adj_val_i && wrap_hi) begin
      skip_nxt  = !stuff_nxt;
      stuff_nxt = 1'b0;
    end else if (adj_val_i && wrap_lo) begin
      stuff_nxt = !skip_nxt;
      skip_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_cnt    <= '0;
      ctr         <= '0;
      tau         <= '0;
      skip_pend   <= 1'b0;
      stuff_pend  <= 1'b0;
      sym_valid_o <= 1'b0;
      slip_o      <= 1'b0;
      stuff_o     <= 1'b0;
      phase_int_o <= '0;
      mu_o        <= '0;
    end else begin
      sym_valid_o <= 1'b0;
      slip_o      <= 1'b0;
      stuff_o     <= 1'b0;

      if (state == FILL && en_i) begin
        if (iq_raw_val_i) fill_cnt <= fill_cnt + FILL_W'(1);
      end else begin
        fill_cnt <= '0;
      end

      if (!run_act) begin
        ctr        <= '0;
        tau        <= '0;
        skip_pend  <= 1'b0;
        stuff_pend <= 1'b0;
      end else begin
        if (iq_raw_val_i) ctr <= ctr_last ? '0 : ctr + CTR_W'(1);
        if (adj_val_i)    tau <= tau_wrap;
        skip_pend  <= skip_nxt;
        stuff_pend <= stuff_nxt;

        // Strobes sample the pre-adjust tau.
        if (strobe_norm && skip_pend) begin
          slip_o <= 1'b1;
        end else if (strobe_norm || stuff_evt) begin
          sym_valid_o <= 1'b1;
          stuff_o     <= stuff_evt;
          phase_int_o <= tau[TAU_W-1 -: 5];
          mu_o        <= tau[FRAC_W-1:0];
        end
      end
    end
  end

endmodule
